// File: rtl/in_reg_skew.sv
// Input skew feeder: lane k is delayed by k+1 advances to build the diagonal wavefront, then drained with zero fill.
// Optional IN_SKEW_LANE_VALID_EN adds out_lane_valid_o, a per-lane tag marking real input data.
module in_reg_skew #(
  parameter int I_WIDTH  = 8,
  parameter int F_WIDTH  = 8,
  parameter int N        = 3,
  parameter int FS_WIDTH = $clog2(N)
) (
  input  logic                             clk_i,
  input  logic                             out_reg_shift_rst_i,
  input  logic [N*(I_WIDTH+F_WIDTH)-1:0]   in_data_i,
  input  logic                             in_valid_i,
  output logic                             in_ready_o,
  input  logic                             last_i,
  input  logic [FS_WIDTH-1:0]              filter_size_i,
  input  logic                             filter_size_ld_i,
  output logic [N*(I_WIDTH+F_WIDTH)-1:0]   out_data_o,
`ifdef IN_SKEW_LANE_VALID_EN
  output logic [N-1:0]                     out_lane_valid_o,
`endif
  output logic                             out_valid_o,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int W = I_WIDTH + F_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              r_state;
  logic [FS_WIDTH-1:0] r_fs;
  logic [FS_WIDTH-1:0] r_cnt;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                r_out_vld;

  logic                w_acc;
  logic                w_adv;
  logic [FS_WIDTH-1:0] w_fs_clamp;

  assign w_acc      = in_valid_i & r_ready;
  assign w_adv      = w_acc | (r_state == S_FLUSH);
  assign w_fs_clamp = (filter_size_i > FS_WIDTH'(N-1)) ? FS_WIDTH'(N-1) : filter_size_i;

  assign in_ready_o  = r_ready;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign out_valid_o = r_out_vld;

  always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
    if (out_reg_shift_rst_i) begin
      r_state   <= S_IDLE;
      r_fs      <= '0;
      r_cnt     <= '0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= w_adv;
      r_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (filter_size_ld_i) r_fs <= w_fs_clamp;
          if (w_acc) begin
            r_busy <= 1'b1;
            if (!last_i) begin
              r_state <= S_STREAM;
            end else if (r_fs == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_ready <= 1'b0;
            end else begin
              r_state <= S_FLUSH;
              r_cnt   <= r_fs;
              r_ready <= 1'b0;
            end
          end
        end
        S_STREAM: begin
          if (w_acc && last_i) begin
            r_ready <= 1'b0;
            if (r_fs == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= S_FLUSH;
              r_cnt   <= r_fs;
            end
          end
        end
        S_FLUSH: begin
          r_cnt <= r_cnt - FS_WIDTH'(1);
          if (r_cnt == FS_WIDTH'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  // Only accepted words on active lanes enter a line; flush and inactive lanes shift in zero.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic [W-1:0] r_dl [0:k];
    logic         w_live;

    assign w_live = w_acc && (k <= int'(r_fs));

    always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
      if (out_reg_shift_rst_i) begin
        for (int j = 0; j <= k; j++) r_dl[j] <= '0;
      end else if (w_adv) begin
        r_dl[0] <= w_live ? in_data_i[k*W +: W] : '0;
        for (int j = 1; j <= k; j++) r_dl[j] <= r_dl[j-1];
      end
    end

    assign out_data_o[k*W +: W] = r_dl[k];

`ifdef IN_SKEW_LANE_VALID_EN
    logic [k:0] r_tag;

    always_ff @(posedge clk_i or posedge out_reg_shift_rst_i) begin
      if (out_reg_shift_rst_i) begin
        r_tag <= '0;
      end else if (w_adv) begin
        r_tag[0] <= w_live;
        for (int j = 1; j <= k; j++) r_tag[j] <= r_tag[j-1];
      end
    end

    assign out_lane_valid_o[k] = r_tag[k];
`endif
  end

endmodule

// File: tb/tb_in_reg_skew.sv
// Bench for in_reg_skew: random and directed streams against a per-lane push-history model.
module tb_in_reg_skew;
  localparam int IW  = 8;
  localparam int FW  = 8;
  localparam int N   = 3;
  localparam int W   = IW + FW;
  localparam int FSW = $clog2(N);

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic               out_reg_shift_rst_i;
  logic [N*W-1:0]     in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic               last_i;
  logic [FSW-1:0]     filter_size_i;
  logic               filter_size_ld_i;
  logic [N*W-1:0]     out_data_o;
  logic               out_valid_o;
  logic               busy_o;
  logic               done_o;
`ifdef IN_SKEW_LANE_VALID_EN
  logic [N-1:0]       out_lane_valid_o;
`endif

  in_reg_skew #(.I_WIDTH(IW), .F_WIDTH(FW), .N(N)) dut (
    .clk_i               (clk_i),
    .out_reg_shift_rst_i (out_reg_shift_rst_i),
    .in_data_i           (in_data_i),
    .in_valid_i          (in_valid_i),
    .in_ready_o          (in_ready_o),
    .last_i              (last_i),
    .filter_size_i       (filter_size_i),
    .filter_size_ld_i    (filter_size_ld_i),
    .out_data_o          (out_data_o),
`ifdef IN_SKEW_LANE_VALID_EN
    .out_lane_valid_o    (out_lane_valid_o),
`endif
    .out_valid_o         (out_valid_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  int errors = 0;
  int checks = 0;

  // Model: every advance pushes one word per lane; lane k shows the push made k advances before the newest.
  logic [N*W-1:0] hist[$];
  logic [N-1:0]   vhist[$];
  int             fs_m = 0;
  logic [N*W-1:0] cap[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_data();
    logic [N*W-1:0] r = '0;
    for (int k = 0; k < N; k++)
      if (hist.size() > k) r[k*W +: W] = hist[hist.size()-1-k][k*W +: W];
    return r;
  endfunction

  function automatic logic [N-1:0] exp_lv();
    logic [N-1:0] r = '0;
    for (int k = 0; k < N; k++)
      if (vhist.size() > k) r[k] = vhist[vhist.size()-1-k][k];
    return r;
  endfunction

  function automatic logic [N*W-1:0] pk(input int a, input int b, input int c);
    return {W'(c), W'(b), W'(a)};
  endfunction

  task automatic check_all(input bit vld, input bit rdy, input bit bsy, input bit dn);
    chk("out_data", 64'(out_data_o), 64'(exp_data()));
    chk("out_valid", 64'(out_valid_o), 64'(vld));
    chk("in_ready", 64'(in_ready_o), 64'(rdy));
    chk("busy", 64'(busy_o), 64'(bsy));
    chk("done", 64'(done_o), 64'(dn));
`ifdef IN_SKEW_LANE_VALID_EN
    chk("lane_valid", 64'(out_lane_valid_o), 64'(exp_lv()));
`endif
  endtask

  // gap_mode: 0 none, 1 one idle cycle before beat 2, 2 random idles.
  task automatic run_stream(input int nb, input int fs_ld, input bit fixed, input int gap_mode,
                            input bit ld_mid, input bit rst_flush);
    logic [N*W-1:0] beats[$];
    int  sent = 0;
    int  post = 0;
    bit  lastacc = 0;
    bit  started = 0;
    bit  gapped = 0;
    bit  exp_vld = 0;
    bit  done_seen = 0;

    cap.delete();
    for (int i = 0; i < nb; i++)
      beats.push_back(fixed ? pk(3*i+1, 3*i+2, 3*i+3) : {$urandom, $urandom});

    filter_size_i    = FSW'(fs_ld);
    filter_size_ld_i = 1'b1;
    @(posedge clk_i); #1;
    filter_size_ld_i = 1'b0;
    fs_m = (fs_ld > N-1) ? N-1 : fs_ld;

    for (int cyc = 0; cyc < 300; cyc++) begin
      bit acc, adv, flush, e_rdy, e_busy, e_done;
      e_rdy  = !lastacc || post >= fs_m + 2;
      flush  = lastacc && post >= 1 && post <= fs_m;
      e_done = lastacc && post == fs_m + 1;
      e_busy = started && !(lastacc && post >= fs_m + 2);

      in_valid_i = 1'b0;
      if (sent < nb) begin
        in_valid_i = 1'b1;
        if (gap_mode == 1 && sent == 1 && !gapped) begin
          in_valid_i = 1'b0;
          gapped = 1;
        end else if (gap_mode == 2 && $urandom_range(0, 2) == 0) begin
          in_valid_i = 1'b0;
        end
      end
      in_data_i        = (sent < nb) ? beats[sent] : {$urandom, $urandom};
      last_i           = (sent == nb - 1);
      filter_size_ld_i = ld_mid && sent > 0 && sent < nb;
      if (ld_mid) filter_size_i = '0;

      if (rst_flush && flush) begin
        out_reg_shift_rst_i = 1'b1;
        hist.delete();
        vhist.delete();
        fs_m = 0;
        #1;
        check_all(0, 1, 0, 0);
        @(posedge clk_i); #1;
        check_all(0, 1, 0, 0);
        out_reg_shift_rst_i = 1'b0;
        in_valid_i = 1'b0;
        filter_size_ld_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk_i);
          check_all(0, 1, 0, 0);
        end
        @(posedge clk_i); #1;
        return;
      end

      @(negedge clk_i);
      check_all(exp_vld, e_rdy, e_busy, e_done);
      if (out_valid_o) cap.push_back(out_data_o);
      if (e_done) done_seen = 1;
      if (lastacc && post == fs_m + 2) begin
        chk("done_seen", 64'(done_seen), 64'd1);
        return;
      end

      acc = in_valid_i && e_rdy;
      adv = acc || flush;
      if (adv) begin
        logic [N*W-1:0] word = '0;
        logic [N-1:0]   tag  = '0;
        for (int k = 0; k < N; k++)
          if (acc && k <= fs_m) begin
            word[k*W +: W] = in_data_i[k*W +: W];
            tag[k] = 1'b1;
          end
        hist.push_back(word);
        vhist.push_back(tag);
      end
      exp_vld = adv;
      if (acc) begin
        started = 1;
        sent++;
        if (last_i) begin
          lastacc = 1;
          post = 0;
        end
      end
      if (lastacc) post++;
      @(posedge clk_i); #1;
    end
    chk("stream_timeout", 64'd1, 64'd0);
  endtask

  task automatic check_table(input int fs);
    logic [N*W-1:0] tbl[$];
    if (fs == 2) tbl = '{pk(1,0,0), pk(4,2,0), pk(7,5,3), pk(0,8,6), pk(0,0,9)};
    else         tbl = '{pk(1,0,0), pk(4,2,0), pk(7,5,0), pk(0,8,0)};
    chk("table_len", 64'(cap.size()), 64'(tbl.size()));
    for (int i = 0; i < tbl.size() && i < cap.size(); i++)
      chk("table_col", 64'(cap[i]), 64'(tbl[i]));
  endtask

  initial begin
    out_reg_shift_rst_i = 1'b1;
    in_data_i = '0;
    in_valid_i = 1'b0;
    last_i = 1'b0;
    filter_size_i = '0;
    filter_size_ld_i = 1'b0;
    #12;
    check_all(0, 1, 0, 0);
    @(posedge clk_i); #1;
    out_reg_shift_rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_stream(3, 2, 1, 0, 0, 0);
    check_table(2);
    run_stream(3, 1, 1, 0, 0, 0);
    check_table(1);
    run_stream(3, 2, 1, 1, 0, 0);
    check_table(2);
    run_stream(3, 2, 1, 0, 1, 0);
    check_table(2);
    run_stream(3, 2, 1, 0, 0, 1);
    run_stream(1, 0, 0, 0, 0, 0);
    run_stream(2, 3, 0, 0, 0, 0);

    for (int r = 0; r < 25; r++)
      run_stream($urandom_range(1, 6), $urandom_range(0, 3), 0,
                 $urandom_range(0, 1) * 2, $urandom_range(0, 1), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
